// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants for the registered ripple-borrow subtractor
// Purpose: holds the default operand width used by the interface and the top level.
// Ports: none (package).
package full_subtractor_pkg;

  // Classic 1-bit full subtractor unless the instantiating datapath asks for more.
  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_subtractor_if.sv
// rtl/full_subtractor_if.sv - operand/result bundle for the subtractor
// Purpose: groups the sampled operands and the registered result with their qualifiers.
// Signals:
//   in_valid  operands are sampled on the next rising edge when high
//   A, B      minuend / subtrahend (unsigned, WIDTH bits)
//   Bin       borrow-in, subtracted at bit 0
//   Diff      registered (A - B - Bin) mod 2^WIDTH
//   Bout      registered borrow-out from the MSB
//   out_valid Diff/Bout hold a result computed from a valid input
// Modports: master drives operands and observes results; slave is the subtractor.
interface full_subtractor_if
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             out_valid;

  modport master (
    output in_valid,
    output A,
    output B,
    output Bin,
    input  Diff,
    input  Bout,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  A,
    input  B,
    input  Bin,
    output Diff,
    output Bout,
    output out_valid
  );

endinterface

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - combinational 1-bit full subtractor cell
// Purpose: one link of the ripple-borrow chain.
// Ports:
//   a     minuend bit
//   b     subtrahend bit
//   bin   borrow from the next lower bit
//   diff  a - b - bin (mod 2)
//   bout  borrow into the next higher bit
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow ripples in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered WIDTH-bit ripple-borrow subtractor
// Purpose: computes A - B - Bin with one cycle of latency and a valid qualifier.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears Diff, Bout and out_valid
//   bus    full_subtractor_if.slave: operands in, registered result out
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  full_subtractor_if.slave     bus
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_comb;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             valid_q;

  assign borrow[0] = bus.Bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (bus.A[i]),
      .b    (bus.B[i]),
      .bin  (borrow[i]),
      .diff (diff_comb[i]),
      .bout (borrow[i+1])
    );
  end

  // Result registers only load on a valid sample, so unknown operands presented
  // while in_valid is low never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q  <= '0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        diff_q <= diff_comb;
        bout_q <= borrow[WIDTH];
      end
    end
  end

  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - self-checking bench for the 1-bit and 8-bit subtractor
module tb_full_subtractor;

  logic clk;
  logic rst_n;

  full_subtractor_if #(.WIDTH(1)) bus1 ();
  full_subtractor_if #(.WIDTH(8)) bus8 ();

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       bo;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  int compared   = 0;
  int mismatched = 0;

  logic       hold1_d, hold1_b;
  logic [7:0] hold8_d;
  logic       hold8_b;

  // 1-bit truth table indexed by {A,B,Bin}, entries are {Diff,Bout}.
  logic [1:0] tt [8];

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic v, input logic a, input logic b, input logic bin,
                       input string tag);
    exp_t e;
    bus1.in_valid = v;
    bus1.A        = a;
    bus1.B        = b;
    bus1.Bin      = bin;
    if (v) begin
      hold1_d = tt[{a, b, bin}][1];
      hold1_b = tt[{a, b, bin}][0];
    end
    e.v  = v;
    e.d  = {7'b0, hold1_d};
    e.bo = hold1_b;
    q1.push_back(e);
    @(posedge clk);
    #1;
    if (q1.size() == 0) begin
      check({tag, "_queue"}, 9'd0, 9'd1);
    end else begin
      e = q1.pop_front();
      check({tag, "_diff"}, {8'b0, bus1.Diff}, {1'b0, e.d});
      check({tag, "_bout"}, {8'b0, bus1.Bout}, {8'b0, e.bo});
      check({tag, "_valid"}, {8'b0, bus1.out_valid}, {8'b0, e.v});
    end
  endtask

  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input string tag);
    exp_t       e;
    logic [8:0] r;
    bus8.in_valid = v;
    bus8.A        = a;
    bus8.B        = b;
    bus8.Bin      = bin;
    if (v) begin
      r       = {1'b0, a} - {1'b0, b} - {8'b0, bin};
      hold8_d = r[7:0];
      hold8_b = r[8];
    end
    e.v  = v;
    e.d  = hold8_d;
    e.bo = hold8_b;
    q8.push_back(e);
    @(posedge clk);
    #1;
    if (q8.size() == 0) begin
      check({tag, "_queue"}, 9'd0, 9'd1);
    end else begin
      e = q8.pop_front();
      check({tag, "_diff"}, {1'b0, bus8.Diff}, {1'b0, e.d});
      check({tag, "_bout"}, {8'b0, bus8.Bout}, {8'b0, e.bo});
      check({tag, "_valid"}, {8'b0, bus8.out_valid}, {8'b0, e.v});
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_d1"}, {8'b0, bus1.Diff}, 9'd0);
    check({tag, "_b1"}, {8'b0, bus1.Bout}, 9'd0);
    check({tag, "_v1"}, {8'b0, bus1.out_valid}, 9'd0);
    check({tag, "_d8"}, {1'b0, bus8.Diff}, 9'd0);
    check({tag, "_b8"}, {8'b0, bus8.Bout}, 9'd0);
    check({tag, "_v8"}, {8'b0, bus8.out_valid}, 9'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;
    hold1_d = 1'b0; hold1_b = 1'b0;
    hold8_d = 8'h00; hold8_b = 1'b0;

    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.A = 1'b0; bus1.B = 1'b0; bus1.Bin = 1'b0;
    bus8.in_valid = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00; bus8.Bin = 1'b0;

    // Reset state, before any clock edge has occurred.
    #3;
    check_cleared("reset_init");
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WIDTH=1 exhaustive, back-to-back.
    for (int i = 0; i < 8; i++) begin
      step1(1'b1, i[2], i[1], i[0], $sformatf("w1_tt%0d", i));
    end

    // WIDTH=1 directed, then an idle cycle with unknown operands.
    step1(1'b1, 1'b0, 1'b1, 1'b1, "w1_011");
    step1(1'b0, 1'bx, 1'bx, 1'bx, "w1_idle_hold");
    step1(1'b0, 1'b1, 1'b0, 1'b0, "w1_idle_hold2");

    // WIDTH=8 directed and wrap-around.
    step8(1'b1, 8'h05, 8'h03, 1'b0, "w8_5m3");
    step8(1'b1, 8'h00, 8'h00, 1'b1, "w8_0m0m1");
    step8(1'b1, 8'h80, 8'h80, 1'b1, "w8_80m80m1");
    step8(1'b1, 8'hFF, 8'h00, 1'b0, "w8_ffm0");
    step8(1'b0, 8'hxx, 8'hxx, 1'bx, "w8_idle_hold");

    // Mid-stream reset between edges.
    step8(1'b1, 8'h12, 8'h34, 1'b0, "w8_pre_reset");
    bus8.in_valid = 1'b1;
    bus8.A = 8'h77; bus8.B = 8'h11; bus8.Bin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("reset_mid");
    hold1_d = 1'b0; hold1_b = 1'b0;
    hold8_d = 8'h00; hold8_b = 1'b0;
    #1;
    rst_n = 1'b1;
    step8(1'b1, 8'h3C, 8'h5A, 1'b1, "w8_post_reset");
    step1(1'b1, 1'b1, 1'b0, 1'b0, "w1_post_reset");

    // Random full-throughput stream.
    for (int n = 0; n < 1000; n++) begin
      step8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), "w8_rand");
    end
    step8(1'b0, 8'h00, 8'h00, 1'b0, "w8_rand_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
